tt3_sweep_ctrl: RTL
===================

Name: tt3_sweep_ctrl

Overview:
- Sequencer that characterizes one 3-input truth-table logic gate (output bit = function of {in1,in2,in3}).
- Drives the gate's in1/in2/in3 through all 8 rows, waits a settle time per row, majority-samples the gate output and assembles an 8-bit truth table.
- Compares the table with an expected hex code (e.g. 8'hA6) and reports pass/fail.
- Sits between the test/config host and any 3-input gate instance.

Parameters:
- SETTLE_CYCLES, 16, cycles each row is held before sampling starts; legal range 1..65535.
- SAMPLES, 3, samples per row for the majority vote; must be odd, 1..15.
- EXPECTED, 8'hA6, expected truth table; bit 7 = row 000, bit 0 = row 111.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin sweep; honoured only in IDLE.
- gate_out  input  1  output of the gate under control.
- in1  output  1  gate input, MSB of row index.
- in2  output  1  gate input, middle bit of row index.
- in3  output  1  gate input, LSB of row index.
- busy  output  1  high from the start acceptance until done.
- done  output  1  one-cycle pulse at sweep completion.
- table_out  output  8  measured truth table; bit (7-i) = result for row i.
- pass  output  1  table_out == EXPECTED; valid while done is high and held afterwards.
- mismatch  output  8  table_out XOR EXPECTED, held the same way as pass.

Behaviour:
- Reset values: in1..3 = 0, busy = 0, done = 0, table_out = 0, pass = 0, mismatch = 0, FSM = IDLE. Reset mid-sweep aborts immediately to these values; no done pulse.
- States:
  - IDLE: in = 000. start=1 → APPLY, row = 0, busy = 1, clear table_out/pass/mismatch.
  - APPLY: in = row. Hold SETTLE_CYCLES cycles (down-counter), then → SAMPLE.
  - SAMPLE: SAMPLES cycles. Count gate_out==1 in a 4-bit counter; the row bit is 1 iff 2*ones > SAMPLES. Write table_out[7-row] on the last sample cycle. Then row < 7 → APPLY with row+1; row == 7 → DONE.
  - DONE: for one cycle, done = 1, busy = 0, pass/mismatch updated → IDLE.
- Row index: 3-bit; in1 = row[2], in2 = row[1], in3 = row[0]. No wrap; the sweep ends after row 7. in1..3 return to 000 in DONE.
- Latency: if start is sampled at edge 0, done is high during cycle 8*(SETTLE_CYCLES+SAMPLES)+1.
- gate_out is sampled only in SAMPLE and ignored elsewhere.
- start while busy or in DONE: ignored, no queuing.
- start and rst in the same cycle: rst wins.
- table_out bits not yet written during a sweep read 0. The full table is stable from done until the next accepted start.

Optional Feature:
- GLITCH_CHECK_EN defined:
  - Adds output port unstable[7:0]; bit (7-i) = 1 if row i's samples were not unanimous.
  - Reset/start clear it, same as table_out.
  - pass additionally requires unstable == 0.
- Undefined: no unstable port; pass depends only on the table comparison; no extra registers.

Test Plan:
- SETTLE_CYCLES=4, SAMPLES=3, gate_out modelled as the 0xA6 function of in1..3; pulse start → done in cycle 57, table_out = 8'hA6, pass = 1, mismatch = 8'h00, busy low after done.
- gate_out tied to 0 → table_out = 8'h00, pass = 0, mismatch = 8'hA6.
- 0xA6 model with gate_out forced opposite on the 2nd of 3 samples in row 5 → table_out = 8'hA6. With GLITCH_CHECK_EN: unstable = 8'h04, pass = 0. Without: pass = 1.
- rst asserted during row 3 APPLY → next cycle in = 000, busy = 0, table_out = 0, no done pulse. A new start then produces a full sweep again.
- start re-pulsed in cycles 10 and 30 of a sweep → ignored, done still in cycle 57. start in the done cycle ignored. start in the cycle after done accepted.
- SAMPLES=1, SETTLE_CYCLES=1 → done in cycle 17; each row is written from a single sample.

Source files
------------

// File: rtl/tt3_sweep_ctrl.sv
// Truth-table sweep controller for one 3-input gate: steps rows 000..111, settles, majority-votes gate_out.
// Optional GLITCH_CHECK_EN adds the unstable[7:0] port flagging rows whose samples disagreed.
module tt3_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 16,
    parameter int          SAMPLES       = 3,
    parameter logic [7:0]  EXPECTED      = 8'hA6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [7:0] mismatch
`ifdef GLITCH_CHECK_EN
    ,
    output logic [7:0] unstable
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE} state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SAMPLE_LOAD = 16'(SAMPLES - 1);

    state_t      state, state_next;
    logic [2:0]  row;
    logic [15:0] cnt;
    logic [3:0]  ones;
    logic [3:0]  ones_next;
    logic        vote;
    logic [7:0]  tbl_next;

    assign ones_next = ones + {3'b000, gate_out};
    // Majority: doubling the count avoids a divide and stays exact for odd SAMPLES.
    assign vote      = {ones_next, 1'b0} > 5'(SAMPLES);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tbl_next       = table_out;
        tbl_next[~row] = vote;
    end

`ifdef GLITCH_CHECK_EN
    logic [7:0] unst_next;
    always_comb begin
        unst_next       = unstable;
        unst_next[~row] = (ones_next != 4'd0) && (ones_next != 4'(SAMPLES));
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_APPLY;
            ST_APPLY:  if (cnt == 16'd0) state_next = ST_SAMPLE;
            ST_SAMPLE: if (cnt == 16'd0) state_next = (row == 3'd7) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_APPLY) || (state == ST_SAMPLE);
        done = (state == ST_DONE);
        {in1, in2, in3} = busy ? row : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= 3'd0;
            cnt       <= 16'd0;
            ones      <= 4'd0;
            table_out <= 8'h00;
            pass      <= 1'b0;
            mismatch  <= 8'h00;
`ifdef GLITCH_CHECK_EN
            unstable  <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    row       <= 3'd0;
                    cnt       <= SETTLE_LOAD;
                    table_out <= 8'h00;
                    pass      <= 1'b0;
                    mismatch  <= 8'h00;
`ifdef GLITCH_CHECK_EN
                    unstable  <= 8'h00;
`endif
                end
                ST_APPLY: begin
                    if (cnt == 16'd0) begin
                        cnt  <= SAMPLE_LOAD;
                        ones <= 4'd0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    ones <= ones_next;
                    if (cnt == 16'd0) begin
                        table_out <= tbl_next;
                        cnt       <= SETTLE_LOAD;
                        row       <= row + 3'd1;
`ifdef GLITCH_CHECK_EN
                        unstable  <= unst_next;
                        if (row == 3'd7) begin
                            pass     <= (tbl_next == EXPECTED) && (unst_next == 8'h00);
                            mismatch <= tbl_next ^ EXPECTED;
                        end
`else
                        if (row == 3'd7) begin
                            pass     <= (tbl_next == EXPECTED);
                            mismatch <= tbl_next ^ EXPECTED;
                        end
`endif
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
